// File: rtl/mdio_pkg.sv
// Shared MDIO clause-22 definitions: frame field widths, opcodes and responder states.
package mdio_pkg;
    localparam int PHY_W  = 5;
    localparam int REG_W  = 5;
    localparam int DATA_W = 16;

    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] ST_PAT = 2'b01;

    typedef enum logic [2:0] {
        S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_RD, S_WR
    } state_t;
endpackage

// File: rtl/mdio_edge_sync.sv
// Two-flop synchronisers for mdc/mdio with an mdc rise-event pulse.
module mdio_edge_sync (
    input  logic clk,
    input  logic rstf,
    input  logic mdc_in,
    input  logic mdio_in,
    output logic mdc_rise,
    output logic mdio_s
);
    logic [2:0] mdc_ff;
    logic [1:0] mdio_ff;

    always_ff @(posedge clk) begin
        if (!rstf) begin
            mdc_ff  <= '0;
            mdio_ff <= '0;
        end else begin
            mdc_ff  <= {mdc_ff[1:0], mdc_in};
            mdio_ff <= {mdio_ff[0], mdio_in};
        end
    end

    // mdio_ff[1] has the same depth as mdc_ff[1], so data is aligned with the rise event
    assign mdc_rise = mdc_ff[1] & ~mdc_ff[2];
    assign mdio_s   = mdio_ff[1];
endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: decodes frames on oversampled mdc, serves an external register bank
// and keeps an internal page-select register that prefixes the external address.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR     = 5'd0,
    parameter logic [4:0] PAGE_REG     = 5'd22,
    parameter int         PAGE_W       = 2,
    parameter int         PREAMBLE_MIN = 32,
    parameter int         MDC_TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  rstf,
    input  logic                  mdc_in,
    input  logic                  mdio_in,
    output logic                  mdio_out,
    output logic                  mdio_oe,
    output logic [PAGE_W-1:0]     page,
    output logic [PAGE_W+4:0]     reg_addr,
    output logic                  reg_rd_req,
    input  logic [DATA_W-1:0]     reg_rdata,
    output logic                  reg_wr,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic                  busy
);
    localparam int PRE_W = $clog2(PREAMBLE_MIN + 2);
    localparam int TMO_W = $clog2(MDC_TIMEOUT + 1);

    typedef struct packed {
        state_t              st;
        logic [PRE_W-1:0]    pre;
        logic [4:0]          bcnt;
        logic                rd;
        logic                match;
        logic                pg_rd;
        logic [REG_W-1:0]    regad;
        logic [DATA_W-1:0]   sh;
        logic [DATA_W-1:0]   rsh;
        logic [TMO_W-1:0]    tmo;
        logic [PAGE_W-1:0]   page;
        logic                oe;
        logic                out;
        logic                rd_req;
        logic                wr;
        logic [PAGE_W+4:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } ctx_t;

    ctx_t q, d;
    logic mdc_rise, mdio_s;
    logic [DATA_W-1:0] sh_nx;

    mdio_edge_sync u_sync (
        .clk     (clk),
        .rstf    (rstf),
        .mdc_in  (mdc_in),
        .mdio_in (mdio_in),
        .mdc_rise(mdc_rise),
        .mdio_s  (mdio_s)
    );

    assign sh_nx = {q.sh[DATA_W-2:0], mdio_s};

    always_ff @(posedge clk) begin
        if (!rstf) q <= '0;
        else       q <= d;
    end

    always_comb begin
        d        = q;
        d.rd_req = 1'b0;
        d.wr     = 1'b0;
        if (mdc_rise) begin
            d.tmo  = '0;
            d.sh   = sh_nx;
            d.bcnt = q.bcnt + 5'd1;
            case (q.st)
                S_PRE: begin
                    d.bcnt = '0;
                    if (mdio_s) begin
                        if (q.pre != '1) d.pre = q.pre + PRE_W'(1);
                    end else if (q.pre >= PRE_W'(PREAMBLE_MIN)) begin
                        d.st  = S_ST;
                        d.pre = '0;
                    end else begin
                        d.pre = '0;
                    end
                end
                S_ST: begin
                    d.bcnt = '0;
                    d.st   = (mdio_s == ST_PAT[0]) ? S_OP : S_PRE;
                end
                S_OP: if (q.bcnt == 5'd1) begin
                    d.bcnt = '0;
                    if (sh_nx[1:0] == OP_RD || sh_nx[1:0] == OP_WR) begin
                        d.st = S_PHY;
                        d.rd = (sh_nx[1:0] == OP_RD);
                    end else begin
                        d.st = S_PRE;
                    end
                end
                S_PHY: if (q.bcnt == 5'(PHY_W - 1)) begin
                    d.bcnt  = '0;
                    d.match = (sh_nx[PHY_W-1:0] == PHY_ADDR);
                    d.st    = S_REG;
                end
                S_REG: if (q.bcnt == 5'(REG_W - 1)) begin
                    d.bcnt  = '0;
                    d.regad = sh_nx[REG_W-1:0];
                    d.pg_rd = (sh_nx[REG_W-1:0] == PAGE_REG);
                    d.st    = S_TA;
                    if (q.match && q.rd && sh_nx[REG_W-1:0] != PAGE_REG) begin
                        d.rd_req = 1'b1;
                        d.addr   = {q.page, sh_nx[REG_W-1:0]};
                    end
                end
                S_TA: begin
                    if (q.rd) begin
                        // first TA rise: capture read data and drive the 0 of the turnaround
                        d.bcnt = '0;
                        d.st   = S_RD;
                        d.oe   = q.match;
                        d.out  = 1'b0;
                        d.rsh  = q.pg_rd ? DATA_W'(q.page) : reg_rdata;
                    end else if (q.bcnt == 5'd1) begin
                        d.bcnt = '0;
                        d.st   = S_WR;
                    end
                end
                S_RD: begin
                    if (q.bcnt == 5'd16) begin
                        d.st   = S_PRE;
                        d.pre  = '0;
                        d.bcnt = '0;
                        d.oe   = 1'b0;
                        d.out  = 1'b0;
                    end else begin
                        d.out = q.match & q.rsh[DATA_W-1];
                        d.rsh = {q.rsh[DATA_W-2:0], 1'b0};
                    end
                end
                S_WR: if (q.bcnt == 5'(DATA_W - 1)) begin
                    d.st   = S_PRE;
                    d.pre  = '0;
                    d.bcnt = '0;
                    if (q.match) begin
                        if (q.regad == PAGE_REG) begin
                            d.page = sh_nx[PAGE_W-1:0];
                        end else begin
                            d.wr    = 1'b1;
                            d.addr  = {q.page, q.regad};
                            d.wdata = sh_nx;
                        end
                    end
                end
                default: d.st = S_PRE;
            endcase
        end else if (q.st != S_PRE) begin
            if (q.tmo == TMO_W'(MDC_TIMEOUT - 1)) begin
                d.st   = S_PRE;
                d.pre  = '0;
                d.bcnt = '0;
                d.tmo  = '0;
                d.oe   = 1'b0;
                d.out  = 1'b0;
            end else begin
                d.tmo = q.tmo + TMO_W'(1);
            end
        end
    end

    assign mdio_out   = q.out;
    assign mdio_oe    = q.oe;
    assign page       = q.page;
    assign reg_addr   = q.addr;
    assign reg_rd_req = q.rd_req;
    assign reg_wr     = q.wr;
    assign reg_wdata  = q.wdata;
    assign busy       = (q.st != S_PRE);
endmodule
